wait_state_counter: RTL and testbench

Parametrised, retriggerable wait-state timer for multi-cycle memory access in the pipeline. Memory stage asserts `start` with a per-request latency; the block counts the access out, raises `valid` a fixed lead before completion for stall/forwarding logic, and signals completion on `done`. Unlike the fixed four-cycle startup counter it replaces, it supports:
- configurable width and latency;
- per-request latency override;
- cancel;
- back-to-back requests.

---
 rtl/wait_state_counter.sv | 93 +++++++++
 tb/tb_wait_state_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wait_state_counter.sv
// Retriggerable wait-state timer: counts a per-request latency, pulses done, raises valid VALID_LEAD early.
// Latency: start accepted in cycle 0 -> done in cycle lat_q; back-to-back restart in the done cycle.
// Backpressure: ready low while counting; start is dropped, not queued. WAIT_CNT_HOLD_EN adds a DONE hold state.
module wait_state_counter #(
   parameter int WIDTH      = 4,
   parameter int LATENCY    = 4,
   parameter int VALID_LEAD = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] lat,
   input  logic             cancel,
   output logic             ready,
   output logic             busy,
   output logic             valid,
   output logic             done,
   output logic [WIDTH-1:0] count
);

   if (WIDTH < 1 || LATENCY < 1 || LATENCY > (1 << WIDTH) - 1 ||
       VALID_LEAD < 0 || VALID_LEAD > LATENCY) begin : g_param_check
      $error("wait_state_counter: illegal WIDTH/LATENCY/VALID_LEAD combination");
   end

   localparam logic [WIDTH-1:0] LAT_W  = WIDTH'(LATENCY);
   localparam logic [WIDTH-1:0] LEAD_W = WIDTH'(VALID_LEAD);
   localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

`ifdef WAIT_CNT_HOLD_EN
   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;
`else
   typedef enum logic {S_IDLE, S_COUNT} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] lat_q, lat_d;
   logic             at_end, in_done, accept;
   logic [WIDTH-1:0] valid_thr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         lat_q   <= LAT_W;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lat_q   <= lat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lat_d   = lat_q;
      in_done = 1'b0;
`ifdef WAIT_CNT_HOLD_EN
      in_done = (state_q == S_DONE);
`endif
      at_end    = (state_q == S_COUNT) && (count_q == lat_q);
      busy      = (state_q == S_COUNT);
      done      = at_end || in_done;
      ready     = (state_q == S_IDLE) || done;
      accept    = start && ready && !cancel;
      // Saturating threshold: a short request shows valid from its first counted cycle.
      valid_thr = (lat_q > LEAD_W) ? (lat_q - LEAD_W) : '0;
      valid     = (busy && (count_q >= valid_thr)) || in_done;
      count     = count_q;

      if (cancel) begin
         state_d = S_IDLE;
         count_d = '0;
      end else if (accept) begin
         state_d = S_COUNT;
         count_d = ONE_W;
         lat_d   = (lat == '0) ? LAT_W : lat;
      end else if (state_q == S_COUNT) begin
         if (!at_end) begin
            count_d = count_q + ONE_W;
         end else begin
`ifdef WAIT_CNT_HOLD_EN
            state_d = S_DONE;
`else
            state_d = S_IDLE;
            count_d = '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_wait_state_counter.sv
// Randomised and directed bench for wait_state_counter against a timestamp-based request model.
module tb_wait_state_counter;
   localparam int W    = 4;
   localparam int LAT  = 4;
   localparam int LEAD = 1;

   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0;
   logic [W-1:0] lat = '0;
   logic         ready, busy, valid, done;
   logic [W-1:0] count;

   int tests = 0, fails = 0;
   // Model: a request is the cycle it was accepted in (t0) plus its latency L.
   int cyc = 0, t0 = 0, L = LAT;
   bit act = 1'b0;
   int e_count;
   bit e_ready, e_busy, e_valid, e_done;
   int o_count;
   bit o_ready, o_busy, o_valid, o_done;

   wait_state_counter #(.WIDTH(W), .LATENCY(LAT), .VALID_LEAD(LEAD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lat(lat), .cancel(cancel),
      .ready(ready), .busy(busy), .valid(valid), .done(done), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act_v, input int exp_v);
      tests++;
      if (act_v != exp_v) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act_v, exp_v, $time);
      end
   endtask

   function automatic void model_eval();
      int el, vthr;
      el   = cyc - t0;
      vthr = (L - LEAD < 1) ? 1 : L - LEAD;
      e_count = 0; e_busy = 1'b0; e_valid = 1'b0; e_done = 1'b0;
      if (act) begin
`ifdef WAIT_CNT_HOLD_EN
         e_count = (el < L) ? el : L;
         e_busy  = (el < L);
         e_done  = (el >= L);
`else
         e_count = el;
         e_busy  = 1'b1;
         e_done  = (el == L);
`endif
         e_valid = (el >= vthr);
      end
      e_ready = !act || e_done;
   endfunction

   // One cycle: check this cycle's outputs mid-cycle, then drive the inputs for the coming edge.
   task automatic step(input bit st, input int l, input bit cn);
      @(negedge clk);
      model_eval();
      o_count = int'(count); o_ready = ready; o_busy = busy; o_valid = valid; o_done = done;
      chk("count", o_count, e_count);
      chk("ready", int'(o_ready), int'(e_ready));
      chk("busy",  int'(o_busy),  int'(e_busy));
      chk("valid", int'(o_valid), int'(e_valid));
      chk("done",  int'(o_done),  int'(e_done));
      start = st; lat = W'(l); cancel = cn;
      if (cn) act = 1'b0;
      else if (st && e_ready) begin
         act = 1'b1; t0 = cyc; L = (l == 0) ? LAT : l;
      end
`ifndef WAIT_CNT_HOLD_EN
      else if (act && (cyc - t0 == L)) act = 1'b0;
`endif
      cyc++;
   endtask

   task automatic chk_idle_lit(input string tag);
      chk({tag, "_count"}, int'(count), 0);
      chk({tag, "_busy"},  int'(busy),  0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_done"},  int'(done),  0);
      chk({tag, "_ready"}, int'(ready), 1);
   endtask

   initial begin
      int ecnt[5];
      bit evld[5], edn[5];
      #2;
      chk_idle_lit("reset");
      @(negedge clk); rst_n = 1'b1;

      // Default latency (lat=0 -> 4): count 1,2,3,4,(0 or held 4).
      step(1, 0, 0);
`ifdef WAIT_CNT_HOLD_EN
      ecnt = '{1, 2, 3, 4, 4}; evld = '{0, 0, 1, 1, 1}; edn = '{0, 0, 0, 1, 1};
`else
      ecnt = '{1, 2, 3, 4, 0}; evld = '{0, 0, 1, 1, 0}; edn = '{0, 0, 0, 1, 0};
`endif
      for (int i = 0; i < 5; i++) begin
         step(0, 0, (i == 4));
         chk("dl_count_lit", o_count, ecnt[i]);
         chk("dl_valid_lit", int'(o_valid), int'(evld[i]));
         chk("dl_done_lit",  int'(o_done),  int'(edn[i]));
      end
      step(0, 0, 0);

      // Back-to-back: lat=2 then lat=3 accepted in the done cycle.
      step(1, 2, 0);
      step(0, 0, 0); chk("b2b_busy1_lit", int'(o_busy), 1);
      step(1, 3, 0); chk("b2b_done2_lit", int'(o_done), 1); chk("b2b_rdy2_lit", int'(o_ready), 1);
      step(0, 0, 0); chk("b2b_count3_lit", o_count, 1);
      step(0, 0, 0); chk("b2b_busy4_lit", int'(o_busy), 1);
      step(0, 0, 1); chk("b2b_done5_lit", int'(o_done), 1); chk("b2b_count5_lit", o_count, 3);
      step(0, 0, 0); chk("b2b_idle6_lit", int'(o_busy), 0);

      // Cancel priority, then cancel mid-request.
      step(1, 5, 1);
      step(1, 6, 0); chk("cp_noacc_lit", int'(o_busy), 0);
      step(0, 0, 0);
      step(0, 0, 1); chk("cp_c2_count_lit", o_count, 2);
      step(0, 0, 0); chk("cp_c3_busy_lit", int'(o_busy), 0); chk("cp_c3_count_lit", o_count, 0);

      // Start held high through a lat=4 request: re-accepted only in the done cycle.
      step(1, 4, 0);
      ecnt = '{1, 2, 3, 4, 1};
      for (int i = 0; i < 5; i++) begin
         step(1, 4, 0);
         chk("hs_count_lit", o_count, ecnt[i]);
      end
      step(0, 0, 1);
      step(0, 0, 0);

`ifdef WAIT_CNT_HOLD_EN
      step(1, 3, 0);
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, (i == 5));
         chk("hold_done_lit", int'(o_done), (i >= 3) ? 1 : 0);
         chk("hold_count_lit", o_count, (i >= 3) ? 3 : i);
      end
      step(0, 0, 0); chk("hold_cancel_lit", o_count, 0);
`endif

      // Reset mid-request: lat=5, rst_n dropped during cycle 3.
      step(1, 5, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("rst_pre_count_lit", int'(count), 3);
      rst_n = 1'b0; start = 1'b0; cancel = 1'b0;
      #1;
      chk_idle_lit("rst_mid");
      act = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(0, 0, 0);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 15) == 0));
      end
      step(0, 0, 1);
      step(0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
